mem_port_arbiter: RTL and testbench

//   Shares one two-port synchronous memory (WIDTH-bit words, 2**DEPTH entries) among NUM_REQ requesters.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one two-port synchronous memory among NUM_REQ requesters. Each
//   cycle up to two requests are granted in round-robin order: the first
//   valid requester found from rr_ptr goes to port 0, and the next one goes
//   to port 1 unless it touches port 0's address with a write on either
//   side. Read data comes back one cycle after the grant, steered to the
//   requester that issued it, with a single-cycle resp_valid pulse.
//
// Ports
//   clock, reset                 single clock, asynchronous active-high reset
//   req_valid/req_write          per-requester request and direction (1=write)
//   req_addr/req_wdata           packed, requester i at [i*DEPTH]/[i*WIDTH]
//   req_ready                    grant; request consumed when valid & ready
//   resp_valid/resp_rdata        registered read response per requester
//   writeEnableN/writeDataN/addressN  memory port N controls (N = 0, 1)
//   readData0/readData1          memory read data, registered inside memory

module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*DEPTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [NUM_REQ*WIDTH-1:0] resp_rdata,
    output logic                     writeEnable0,
    output logic [WIDTH-1:0]         writeData0,
    output logic [DEPTH-1:0]         address0,
    input  logic [WIDTH-1:0]         readData0,
    output logic                     writeEnable1,
    output logic [WIDTH-1:0]         writeData1,
    output logic [DEPTH-1:0]         address1,
    input  logic [WIDTH-1:0]         readData1
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Unpacked views of the per-requester address and data slices.
    logic [DEPTH-1:0] addr_a  [NUM_REQ];
    logic [WIDTH-1:0] wdata_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_a[gi]  = req_addr[gi*DEPTH +: DEPTH];
        assign wdata_a[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end

    // State
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               r0_vld_q, r0_vld_d;
    logic [PTR_W-1:0]   r0_id_q,  r0_id_d;
    logic               r1_vld_q, r1_vld_d;
    logic [PTR_W-1:0]   r1_id_q,  r1_id_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;

    // Arbitration results
    logic               g0_vld, g1_vld;
    logic [PTR_W-1:0]   g0_idx, g1_idx;
    logic [NUM_REQ-1:0] grant;

    // Round-robin scan starting at rr_ptr. Port 1 takes the next requester
    // that does not collide with port 0: same address with a write on either
    // side is skipped so the scan can still find a compatible candidate.
    always_comb begin : arb_scan
        logic [PTR_W-1:0] idx;
        g0_vld = 1'b0;
        g0_idx = '0;
        g1_vld = 1'b0;
        g1_idx = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = idx;
                end else if (!g1_vld &&
                             !((addr_a[idx] == addr_a[g0_idx]) &&
                               (req_write[idx] || req_write[g0_idx]))) begin
                    g1_vld = 1'b1;
                    g1_idx = idx;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (g0_vld) grant[g0_idx] = 1'b1;
        if (g1_vld) grant[g1_idx] = 1'b1;
    end

    // Grants are suppressed while reset is high so nothing is consumed and
    // no memory write is issued during reset.
    assign req_ready = reset ? '0 : grant;

    // Memory port drive. An idle port reads address 0 with zero write data.
    always_comb begin
        writeEnable0 = 1'b0;
        address0     = '0;
        writeData0   = '0;
        writeEnable1 = 1'b0;
        address1     = '0;
        writeData1   = '0;
        if (g0_vld && !reset) begin
            writeEnable0 = req_write[g0_idx];
            address0     = addr_a[g0_idx];
            writeData0   = req_write[g0_idx] ? wdata_a[g0_idx] : '0;
        end
        if (g1_vld && !reset) begin
            writeEnable1 = req_write[g1_idx];
            address1     = addr_a[g1_idx];
            writeData1   = req_write[g1_idx] ? wdata_a[g1_idx] : '0;
        end
    end

    // Next state: pointer moves past the last granted requester in scan
    // order (port 1 when it was granted, otherwise port 0).
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (g1_vld) begin
            rr_ptr_d = PTR_W'((int'(g1_idx) + 1) % NUM_REQ);
        end else if (g0_vld) begin
            rr_ptr_d = PTR_W'((int'(g0_idx) + 1) % NUM_REQ);
        end

        r0_vld_d     = g0_vld && !req_write[g0_idx];
        r0_id_d      = g0_idx;
        r1_vld_d     = g1_vld && !req_write[g1_idx];
        r1_id_d      = g1_idx;
        resp_valid_d = '0;
        if (r0_vld_d) resp_valid_d[g0_idx] = 1'b1;
        if (r1_vld_d) resp_valid_d[g1_idx] = 1'b1;
    end

    // Reset drops any read in flight: its response registers are cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            r0_vld_q     <= 1'b0;
            r0_id_q      <= '0;
            r1_vld_q     <= 1'b0;
            r1_id_q      <= '0;
            resp_valid_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            r0_vld_q     <= r0_vld_d;
            r0_id_q      <= r0_id_d;
            r1_vld_q     <= r1_vld_d;
            r1_id_q      <= r1_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid = resp_valid_q;

    // The memory registers its read data, so readDataN lines up with the
    // response registers captured at the same edge.
    for (genvar gr = 0; gr < NUM_REQ; gr++) begin : g_resp
        assign resp_rdata[gr*WIDTH +: WIDTH] =
            (r1_vld_q && (r1_id_q == PTR_W'(gr))) ? readData1 :
            (r0_vld_q && (r0_id_q == PTR_W'(gr))) ? readData0 : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps with a scoreboard queue of
// expected read responses and a shadow copy of the memory contents.

module tb_mem_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 4;
    localparam int WIDTH   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_write, req_ready, resp_valid;
    logic [15:0] req_addr, req_wdata, resp_rdata;
    logic        writeEnable0, writeEnable1;
    logic [3:0]  writeData0, writeData1, address0, address1;
    logic [3:0]  readData0, readData1;

    mem_port_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .writeEnable0(writeEnable0), .writeData0(writeData0), .address0(address0),
        .readData0(readData0),
        .writeEnable1(writeEnable1), .writeData1(writeData1), .address1(address1),
        .readData1(readData1)
    );

    always #5 clock = ~clock;

    // Two-port synchronous memory model
    logic       mem_init;
    logic [3:0] mem [16];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i) ^ 4'h5;
        end else begin
            if (writeEnable0) mem[address0] <= writeData0;
            if (writeEnable1) mem[address1] <= writeData1;
        end
        readData0 <= mem[address0];
        readData1 <= mem[address1];
    end

    typedef struct {
        int         due;
        int         id;
        logic [3:0] data;
    } resp_t;

    resp_t      sb[$];
    logic [3:0] shadow [16];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_resp();
        logic [3:0] ev;
        logic [3:0] ed [4];
        resp_t      e;
        ev = '0;
        for (int i = 0; i < 4; i++) ed[i] = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            ev[e.id] = 1'b1;
            ed[e.id] = e.data;
        end
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) chk($sformatf("resp_rdata%0d", i), 32'(resp_rdata[i*4 +: 4]), 32'(ed[i]));
        end
    endtask

    // One cycle: drive the request, check grants/ports/responses at the
    // falling edge, then record expected read data and shadow writes.
    task automatic step(input logic [3:0] v, input logic [3:0] w,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] exp_ready, input logic [1:0] exp_we);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clock);
        cyc++;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("write_enables", 32'({writeEnable1, writeEnable0}), 32'(exp_we));
        if (v == 4'b0000) begin
            chk("idle_addr", 32'({address1, address0}), 32'h0);
            chk("idle_wdata", 32'({writeData1, writeData0}), 32'h0);
        end
        check_resp();
        for (int i = 0; i < 4; i++) begin
            if (exp_ready[i] && !w[i]) sb.push_back('{cyc + 1, i, shadow[a[i*4 +: 4]]});
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_ready[i] && w[i]) shadow[a[i*4 +: 4]] = d[i*4 +: 4];
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 4'(i) ^ 4'h5;
        reset     = 1'b1;
        mem_init  = 1'b1;
        req_valid = 4'b1111;
        req_write = 4'b1111;
        req_addr  = 16'h1234;
        req_wdata = 16'hFFFF;

        // Initial reset with all requests pending
        @(negedge clock);
        cyc++;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_we", 32'({writeEnable1, writeEnable0}), 32'h0);
        chk("rst_addr", 32'({address1, address0}), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        mem_init = 1'b0;

        // Single write then read of addr 3
        step(4'b0001, 4'b0001, 16'h0003, 16'h000A, 4'b0001, 2'b01);
        step(4'b0001, 4'b0000, 16'h0003, 16'h0000, 4'b0001, 2'b00);
        step(4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 2'b00);

        // Bring rr_ptr to 0, then all four reading: {0,1},{2,3},{0,1}
        step(4'b1000, 4'b0000, 16'h0000, 16'h0000, 4'b1000, 2'b00);
        step(4'b1111, 4'b0000, 16'h7654, 16'h0000, 4'b0011, 2'b00);
        step(4'b1111, 4'b0000, 16'h7654, 16'h0000, 4'b1100, 2'b00);
        step(4'b1111, 4'b0000, 16'h7654, 16'h0000, 4'b0011, 2'b00);
        step(4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 2'b00);

        // rr_ptr -> 1, then two writes to addr 5: req1 first, req2 next
        step(4'b0001, 4'b0000, 16'h0000, 16'h0000, 4'b0001, 2'b00);
        step(4'b0110, 4'b0110, 16'h0550, 16'h0210, 4'b0010, 2'b01);
        step(4'b0100, 4'b0100, 16'h0550, 16'h0210, 4'b0100, 2'b01);
        step(4'b0001, 4'b0000, 16'h0005, 16'h0000, 4'b0001, 2'b00);

        // rr_ptr -> 0, write addr2 by req0 defers read of addr2 by req1
        step(4'b1000, 4'b0000, 16'h0000, 16'h0000, 4'b1000, 2'b00);
        step(4'b0011, 4'b0001, 16'h0022, 16'h0007, 4'b0001, 2'b01);
        step(4'b0010, 4'b0000, 16'h0020, 16'h0000, 4'b0010, 2'b00);

        // Write on port 0 and read on port 1 to different addresses
        step(4'b1100, 4'b0100, 16'h9800, 16'h0300, 4'b1100, 2'b01);
        // Two writes to different addresses, then read both back
        step(4'b0011, 4'b0011, 16'h00BA, 16'h00DE, 4'b0011, 2'b11);
        step(4'b0011, 4'b0000, 16'h00BA, 16'h0000, 4'b0011, 2'b00);
        // Two reads of the same address are both granted
        step(4'b0101, 4'b0000, 16'h0A0A, 16'h0000, 4'b0101, 2'b00);

        // Read granted (req1, port 0) alongside a write (req0, port 1)
        step(4'b0011, 4'b0001, 16'h003F, 16'h0009, 4'b0011, 2'b10);

        // Reset one cycle after the read grant: response is dropped
        req_valid = 4'b1111;
        req_write = 4'b0000;
        req_addr  = 16'h213F;
        reset     = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_ready_now", 32'(req_ready), 32'h0);
        chk("mid_rst_we_now", 32'({writeEnable1, writeEnable0}), 32'h0);
        @(negedge clock);
        cyc++;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_addr", 32'({address1, address0}), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // After release grants restart from req0; write before reset stuck
        step(4'b1111, 4'b0000, 16'h213F, 16'h0000, 4'b0011, 2'b00);
        step(4'b1111, 4'b0000, 16'h213F, 16'h0000, 4'b1100, 2'b00);
        step(4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 2'b00);
        step(4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 2'b00);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
